// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus an optional shift-add multiplier.
// Define ALU_MUL_EN to build the iterative MUL; otherwise Op 110 completes at once flagged Illegal.
module alu_multicycle #(
  parameter int WIDTH = 24
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             CarryOut,
  output logic             Illegal
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;
  localparam logic [WIDTH-1:0] SHIFT_LIMIT = (WIDTH)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
`ifdef ALU_MUL_EN
    MUL,
`endif
    DONE
  } state_t;

  state_t state, next_state, start_state;
  logic accept;

  logic [WIDTH:0]   add_sum, sub_sum;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf, alu_carry, alu_illegal;

  // Overflow as sign-mismatch is equivalent to carry-into-MSB XOR carry-out.
  assign add_sum = {1'b0, A} + {1'b0, B};
  assign sub_sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
  assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    alu_res     = '0;
    alu_ovf     = 1'b0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    case (Op)
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_ADD: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_ovf   = add_ovf;
        alu_carry = add_sum[WIDTH];
      end
      OP_SUB: begin
        alu_res   = sub_sum[WIDTH-1:0];
        alu_ovf   = sub_ovf;
        alu_carry = sub_sum[WIDTH];
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ sub_ovf};
      OP_SLL: alu_res = (B >= SHIFT_LIMIT) ? '0 : (A << B);
`ifdef ALU_MUL_EN
      OP_MUL: alu_res = '0;
`else
      OP_MUL: alu_illegal = 1'b1;
`endif
      OP_NOR: alu_res = ~(A | B);
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod, prod_next;
  logic [WIDTH:0]     partial;
  logic [CNT_W-1:0]   iter;
  logic               last_iter;

  // prod starts as {0, multiplier}; each step adds the multiplicand into the upper half and shifts right.
  assign partial   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {partial, prod[WIDTH-1:1]};
  assign last_iter = (iter == CNT_W'(WIDTH - 1));
  assign start_state = (Op == OP_MUL) ? MUL : DONE;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mcand <= '0;
      prod  <= '0;
      iter  <= '0;
    end else if (accept) begin
      mcand <= A;
      prod  <= {{WIDTH{1'b0}}, B};
      iter  <= '0;
    end else if (state == MUL) begin
      prod <= prod_next;
      iter <= iter + CNT_W'(1);
    end
  end
`else
  assign start_state = DONE;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  // InReady is gated by Reset so nothing is accepted while reset is held.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    InReady = Reset;
      DONE:    InReady = Reset && OutReady;
      default: InReady = 1'b0;
    endcase
    accept = InValid && InReady;
    case (state)
      IDLE: if (accept) next_state = start_state;
`ifdef ALU_MUL_EN
      MUL:  if (last_iter) next_state = DONE;
`endif
      DONE: begin
        if (accept)        next_state = start_state;
        else if (OutReady) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign OutValid = (state == DONE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Result   <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
      Illegal  <= 1'b0;
    end else if (accept) begin
      Result   <= alu_res;
      Zero     <= (alu_res == '0);
      Overflow <= alu_ovf;
      CarryOut <= alu_carry;
      Illegal  <= alu_illegal;
    end
`ifdef ALU_MUL_EN
    else if (state == MUL && last_iter) begin
      Result   <= prod_next[WIDTH-1:0];
      Zero     <= (prod_next[WIDTH-1:0] == '0);
      Overflow <= |prod_next[2*WIDTH-1:WIDTH];
      CarryOut <= 1'b0;
      Illegal  <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle (WIDTH=24); exercises the MUL datapath only when ALU_MUL_EN is defined.
module tb_alu_multicycle;

  localparam int W = 24;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         InValid = 1'b0;
  logic         InReady;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   Op = 3'b000;
  logic         OutValid;
  logic         OutReady = 1'b0;
  logic [W-1:0] Result;
  logic         Zero, Overflow, CarryOut, Illegal;

  int checkCount = 0;
  int failCount  = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .A(A), .B(B), .Op(Op), .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .Zero(Zero), .Overflow(Overflow), .CarryOut(CarryOut), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one request, confirms it is accepted, then scrambles the inputs.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    A = a; B = b; Op = op; InValid = 1'b1;
    #1;
    checkOutput("accept_ready", InReady, 1'b1);
    @(posedge Clock); #1;
    InValid = 1'b0;
    A = 24'h123456; B = 24'h0F0F0F; Op = OP_ADD;
  endtask

  task automatic checkResult(input string tag, input logic [W-1:0] res, input logic z,
                             input logic ovf, input logic cy, input logic ill);
    checkOutput({tag, "_valid"}, OutValid, 1'b1);
    checkOutput({tag, "_result"}, Result, res);
    checkOutput({tag, "_zero"}, Zero, z);
    checkOutput({tag, "_ovf"}, Overflow, ovf);
    checkOutput({tag, "_carry"}, CarryOut, cy);
    checkOutput({tag, "_illegal"}, Illegal, ill);
  endtask

  task automatic drain();
    OutReady = 1'b1;
    @(posedge Clock); #1;
    OutReady = 1'b0;
    checkOutput("drain_valid", OutValid, 1'b0);
  endtask

  initial begin
    logic bad;
    #2;
    checkOutput("rst_valid", OutValid, 1'b0);
    checkOutput("rst_result", Result, 0);
    checkOutput("rst_zero", Zero, 1'b0);
    checkOutput("rst_flags", {Overflow, CarryOut, Illegal}, 3'b000);
    checkOutput("rst_inready", InReady, 1'b0);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    #1 checkOutput("rel_inready", InReady, 1'b1);

    applyStimulus(24'h7FFFFF, 24'h000001, OP_ADD);
    checkResult("add_ovf", 24'h800000, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("add_ovf_inready", InReady, 1'b0);
    drain();
    applyStimulus(24'hFFFFFF, 24'h000001, OP_ADD);
    checkResult("add_carry", 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();
    applyStimulus(24'h000005, 24'h000005, OP_SUB);
    checkResult("sub_eq", 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();
    applyStimulus(24'h800000, 24'h000001, OP_SUB);
    checkResult("sub_ovf", 24'h7FFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();
    applyStimulus(24'hFFFFFF, 24'h000001, OP_SLT);
    checkResult("slt_neg", 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    applyStimulus(24'h000001, 24'hFFFFFF, OP_SLT);
    checkResult("slt_pos", 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    applyStimulus(24'h000001, 24'd23, OP_SLL);
    checkResult("sll_23", 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    applyStimulus(24'h000001, 24'd24, OP_SLL);
    checkResult("sll_24", 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    applyStimulus(24'hFF00FF, 24'h0F0F0F, OP_AND);
    checkResult("and", 24'h0F000F, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    applyStimulus(24'hF0F0F0, 24'h0F0000, OP_NOR);
    checkResult("nor", 24'h000F0F, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

`ifdef ALU_MUL_EN
    applyStimulus(24'h001000, 24'h001000, OP_MUL);
    bad = 1'b0;
    checkOutput("mul_c1_valid", OutValid, 1'b0);
    checkOutput("mul_c1_inready", InReady, 1'b0);
    repeat (23) begin
      @(posedge Clock); #1;
      if (OutValid || InReady) bad = 1'b1;
    end
    checkOutput("mul_busy_quiet", bad, 1'b0);
    @(posedge Clock); #1;
    checkResult("mul_big", 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    applyStimulus(24'h000007, 24'h000006, OP_MUL);
    repeat (24) @(posedge Clock);
    #1 checkResult("mul_small", 24'h00002A, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
`else
    applyStimulus(24'h001000, 24'h001000, OP_MUL);
    checkResult("mul_illegal", 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();
`endif

    applyStimulus(24'h000003, 24'h000004, OP_ADD);
    bad = 1'b0;
    repeat (5) begin
      @(posedge Clock); #1;
      if (!OutValid || Result !== 24'h000007 || InReady) bad = 1'b1;
    end
    checkOutput("bp_hold_bad", bad, 1'b0);
    checkResult("bp_add", 24'h000007, 1'b0, 1'b0, 1'b0, 1'b0);
    A = 24'h0000F0; B = 24'h00000F; Op = OP_OR; InValid = 1'b1; OutReady = 1'b1;
    #1 checkOutput("b2b_inready", InReady, 1'b1);
    @(posedge Clock); #1;
    InValid = 1'b0; OutReady = 1'b0;
    checkResult("b2b_or", 24'h0000FF, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

`ifdef ALU_MUL_EN
    applyStimulus(24'h000003, 24'h000005, OP_MUL);
    repeat (9) @(posedge Clock);
`else
    applyStimulus(24'h000003, 24'h000005, OP_ADD);
`endif
    #1 Reset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", OutValid, 1'b0);
    checkOutput("mid_rst_result", Result, 0);
    checkOutput("mid_rst_inready", InReady, 1'b0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    #1 checkOutput("mid_rel_inready", InReady, 1'b1);
    bad = 1'b0;
    repeat (30) begin
      @(posedge Clock); #1;
      if (OutValid) bad = 1'b1;
    end
    checkOutput("mid_rel_no_valid", bad, 1'b0);

    applyStimulus(24'h000002, 24'h000002, OP_ADD);
    checkResult("post_rst_add", 24'h000004, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
